// File: rtl/motoro3_deadtime_guard.sv
// -----------------------------------------------------------------------------
// motoro3_deadtime_guard
//
// Gate-driver guard for a 3-phase bridge. Each phase takes a raw high/low
// request pair and produces registered gate outputs that never enable both
// sides together and always leave DEAD_CYC clock cycles with both gates off
// between handovers. An external over-current input blanks every gate and
// sets a sticky fault flag. Requests with both sides asserted are latched
// into a sticky per-phase flag for firmware.
//
// Parameters
//   DEAD_W    width of the dead-time counter
//   DEAD_CYC  dead time in clk cycles, 1 .. 2**DEAD_W-1
//
// Ports
//   clk            system clock
//   nRst           asynchronous active-low reset
//   aHp/aLp        phase A high/low-side requests
//   bHp/bLp        phase B high/low-side requests
//   cHp/cLp        phase C high/low-side requests
//   faultIn        over-current, active high, asynchronous to clk
//   faultClr       one-cycle pulse, clears fault and illegal-request flags
//   aHo/aLo        phase A gate outputs (registered)
//   bHo/bLo        phase B gate outputs (registered)
//   cHo/cLo        phase C gate outputs (registered)
//   m3fault        sticky, fault blanking active
//   illReq[2:0]    sticky per phase ([2]=C [1]=B [0]=A), H=L=1 request seen
// -----------------------------------------------------------------------------
module motoro3_deadtime_guard #(
    parameter int unsigned DEAD_W   = 8,
    parameter int unsigned DEAD_CYC = 20
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       aHp,
    input  logic       aLp,
    input  logic       bHp,
    input  logic       bLp,
    input  logic       cHp,
    input  logic       cLp,
    input  logic       faultIn,
    input  logic       faultClr,
    output logic       aHo,
    output logic       aLo,
    output logic       bHo,
    output logic       bLo,
    output logic       cHo,
    output logic       cLo,
    output logic       m3fault,
    output logic [2:0] illReq
);

    localparam logic [2:0] ST_OFF   = 3'd0;
    localparam logic [2:0] ST_HIGH  = 3'd1;
    localparam logic [2:0] ST_LOW   = 3'd2;
    localparam logic [2:0] ST_DEAD  = 3'd3;
    localparam logic [2:0] ST_FAULT = 3'd4;

    localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYC - 1);

    // Per-phase request pairs, index 0=A 1=B 2=C, bit 1 = high side.
    logic [2:0][1:0] req;
    assign req[0] = {aHp, aLp};
    assign req[1] = {bHp, bLp};
    assign req[2] = {cHp, cLp};

    logic fault_s1_q;
    logic fault_s2_q;   // synchronized faultIn (faultS)

    logic [2:0][2:0]        state_q, state_d;
    logic [2:0][DEAD_W-1:0] cnt_q,   cnt_d;
    logic [2:0][1:0]        gate_q,  gate_d;
    logic                   m3fault_q, m3fault_d;
    logic [2:0]             ill_q,   ill_d;

    function automatic logic [2:0] req_target(input logic [1:0] r);
        case (r)
            2'b10:   return ST_HIGH;
            2'b01:   return ST_LOW;
            default: return ST_OFF;
        endcase
    endfunction

    function automatic logic [1:0] gate_decode(input logic [2:0] s);
        case (s)
            ST_HIGH: return 2'b10;
            ST_LOW:  return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gate_d  = '0;
        for (int unsigned p = 0; p < 3; p++) begin
            if (fault_s2_q) begin
                state_d[p] = ST_FAULT;
                cnt_d[p]   = '0;
            end else begin
                case (state_q[p])
                    ST_OFF: state_d[p] = req_target(req[p]);
                    ST_HIGH: begin
                        if (req[p] != 2'b10) begin
                            state_d[p] = ST_DEAD;
                            cnt_d[p]   = DEAD_LOAD;
                        end
                    end
                    ST_LOW: begin
                        if (req[p] != 2'b01) begin
                            state_d[p] = ST_DEAD;
                            cnt_d[p]   = DEAD_LOAD;
                        end
                    end
                    ST_DEAD: begin
                        // Only the request present at expiry matters; changes
                        // mid-count neither restart nor extend it.
                        if (cnt_q[p] != '0) begin
                            cnt_d[p] = cnt_q[p] - 1'b1;
                        end else begin
                            state_d[p] = req_target(req[p]);
                        end
                    end
                    ST_FAULT: begin
                        // Leaving fault always passes through a full dead time
                        // since the gate state before the fault is unknown.
                        if (faultClr) begin
                            state_d[p] = ST_DEAD;
                            cnt_d[p]   = DEAD_LOAD;
                        end
                    end
                    default: begin
                        state_d[p] = ST_OFF;
                        cnt_d[p]   = '0;
                    end
                endcase
            end
            // Registering the decode of the next state keeps the outputs a
            // glitch-free decode of the current state.
            gate_d[p] = gate_decode(state_d[p]);
        end
    end

    always_comb begin
        m3fault_d = m3fault_q;
        if (fault_s2_q) begin
            m3fault_d = 1'b1;
        end else if (faultClr) begin
            m3fault_d = 1'b0;
        end
    end

    // A clear on the same edge as an illegal request loses: set wins.
    always_comb begin
        ill_d = (faultClr && !fault_s2_q) ? '0 : ill_q;
        for (int unsigned p = 0; p < 3; p++) begin
            if (req[p] == 2'b11) begin
                ill_d[p] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            fault_s1_q <= 1'b0;
            fault_s2_q <= 1'b0;
            state_q    <= {3{ST_OFF}};
            cnt_q      <= '0;
            gate_q     <= '0;
            m3fault_q  <= 1'b0;
            ill_q      <= '0;
        end else begin
            fault_s1_q <= faultIn;
            fault_s2_q <= fault_s1_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gate_q     <= gate_d;
            m3fault_q  <= m3fault_d;
            ill_q      <= ill_d;
        end
    end

    assign {aHo, aLo} = gate_q[0];
    assign {bHo, bLo} = gate_q[1];
    assign {cHo, cLo} = gate_q[2];
    assign m3fault    = m3fault_q;
    assign illReq     = ill_q;

endmodule

// File: tb/tb_motoro3_deadtime_guard.sv
module tb_motoro3_deadtime_guard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic nRst;
    logic aHp, aLp, bHp, bLp, cHp, cLp;
    logic faultIn, faultClr;

    // Gate vectors {aHo,aLo,bHo,bLo,cHo,cLo} for each dead-time variant.
    logic [5:0] g20, g1, g255;
    logic       m20, m1, m255;
    logic [2:0] i20, i1, i255;

    int vectors    = 0;
    int miscompares = 0;

    motoro3_deadtime_guard #(.DEAD_W(8), .DEAD_CYC(20)) u_dut20 (
        .clk(clk), .nRst(nRst),
        .aHp(aHp), .aLp(aLp), .bHp(bHp), .bLp(bLp), .cHp(cHp), .cLp(cLp),
        .faultIn(faultIn), .faultClr(faultClr),
        .aHo(g20[5]), .aLo(g20[4]), .bHo(g20[3]), .bLo(g20[2]),
        .cHo(g20[1]), .cLo(g20[0]),
        .m3fault(m20), .illReq(i20)
    );

    motoro3_deadtime_guard #(.DEAD_W(8), .DEAD_CYC(1)) u_dut1 (
        .clk(clk), .nRst(nRst),
        .aHp(aHp), .aLp(aLp), .bHp(bHp), .bLp(bLp), .cHp(cHp), .cLp(cLp),
        .faultIn(faultIn), .faultClr(faultClr),
        .aHo(g1[5]), .aLo(g1[4]), .bHo(g1[3]), .bLo(g1[2]),
        .cHo(g1[1]), .cLo(g1[0]),
        .m3fault(m1), .illReq(i1)
    );

    motoro3_deadtime_guard #(.DEAD_W(8), .DEAD_CYC(255)) u_dut255 (
        .clk(clk), .nRst(nRst),
        .aHp(aHp), .aLp(aLp), .bHp(bHp), .bLp(bLp), .cHp(cHp), .cLp(cLp),
        .faultIn(faultIn), .faultClr(faultClr),
        .aHo(g255[5]), .aLo(g255[4]), .bHo(g255[3]), .bLo(g255[2]),
        .cHo(g255[1]), .cLo(g255[0]),
        .m3fault(m255), .illReq(i255)
    );

    function automatic logic [1:0] ph(input logic [5:0] v, input int p);
        return v[5-2*p -: 2];
    endfunction

    function automatic logic [5:0] get_g(input int k);
        case (k)
            0:       return g20;
            1:       return g1;
            default: return g255;
        endcase
    endfunction

    function automatic logic [2:0] get_i(input int k);
        case (k)
            0:       return i20;
            1:       return i1;
            default: return i255;
        endcase
    endfunction

    function automatic logic get_m(input int k);
        case (k)
            0:       return m20;
            1:       return m1;
            default: return m255;
        endcase
    endfunction

    task automatic set_req(input int p, input logic [1:0] r);
        case (p)
            0:       {aHp, aLp} = r;
            1:       {bHp, bLp} = r;
            default: {cHp, cLp} = r;
        endcase
    endtask

    task automatic do_reset();
        nRst = 1'b0;
        {aHp, aLp, bHp, bLp, cHp, cLp} = '0;
        faultIn  = 1'b0;
        faultClr = 1'b0;
        repeat (2) @(negedge clk);
        nRst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        nRst = 1'b0;
        {aHp, aLp, bHp, bLp, cHp, cLp} = '0;
        faultIn  = 1'b0;
        faultClr = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (g20 !== 6'b0 || m20 !== 1'b0 || i20 !== 3'b0) begin
            miscompares++;
            $display("FAIL reset_state: got g=%b m=%b i=%b expected 000000 0 000", g20, m20, i20);
        end
        nRst = 1'b1;
        @(negedge clk);
        set_req(0, 2'b10);
        @(negedge clk);
        vectors++;
        if (ph(g20, 0) !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_pre_async: got A=%b expected 10", ph(g20, 0));
        end
        #2 nRst = 1'b0;
        #1;
        vectors++;
        if (g20 !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_async: got g=%b expected 000000", g20);
        end
        do_reset();
    endtask

    task automatic test_a_handover();
        do_reset();
        set_req(0, 2'b10);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            vectors++;
            if (ph(g20, 0) !== 2'b10) begin
                miscompares++;
                $display("FAIL a_high cyc%0d: got %b expected 10", i, ph(g20, 0));
            end
        end
        set_req(0, 2'b01);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vectors++;
            if (ph(g20, 0) !== 2'b00) begin
                miscompares++;
                $display("FAIL a_dead cyc%0d: got %b expected 00", i, ph(g20, 0));
            end
        end
        @(negedge clk);
        vectors++;
        if (ph(g20, 0) !== 2'b01) begin
            miscompares++;
            $display("FAIL a_low_after_dead: got %b expected 01", ph(g20, 0));
        end
    endtask

    task automatic test_b_bounce();
        do_reset();
        set_req(1, 2'b10);
        repeat (2) begin
            @(negedge clk);
            vectors++;
            if (ph(g20, 1) !== 2'b10) begin
                miscompares++;
                $display("FAIL b_high: got %b expected 10", ph(g20, 1));
            end
        end
        set_req(1, 2'b01);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vectors++;
            if (ph(g20, 1) !== 2'b00) begin
                miscompares++;
                $display("FAIL b_dead cyc%0d: got %b expected 00", i, ph(g20, 1));
            end
            if (i == 2) set_req(1, 2'b10);
        end
        @(negedge clk);
        vectors++;
        if (ph(g20, 1) !== 2'b10) begin
            miscompares++;
            $display("FAIL b_high_return: got %b expected 10", ph(g20, 1));
        end
    endtask

    task automatic test_c_illegal();
        do_reset();
        set_req(2, 2'b01);
        @(negedge clk);
        vectors++;
        if (ph(g20, 2) !== 2'b01) begin
            miscompares++;
            $display("FAIL c_low: got %b expected 01", ph(g20, 2));
        end
        set_req(2, 2'b11);
        @(negedge clk);
        set_req(2, 2'b01);
        for (int i = 0; i < 20; i++) begin
            vectors++;
            if (ph(g20, 2) !== 2'b00 || i20 !== 3'b100) begin
                miscompares++;
                $display("FAIL c_dead cyc%0d: got C=%b ill=%b expected 00 100", i, ph(g20, 2), i20);
            end
            @(negedge clk);
        end
        vectors++;
        if (ph(g20, 2) !== 2'b01) begin
            miscompares++;
            $display("FAIL c_low_after_dead: got %b expected 01", ph(g20, 2));
        end
        faultClr = 1'b1;
        @(negedge clk);
        faultClr = 1'b0;
        vectors++;
        if (i20 !== 3'b000 || ph(g20, 2) !== 2'b01 || m20 !== 1'b0) begin
            miscompares++;
            $display("FAIL c_clear: got ill=%b C=%b m=%b expected 000 01 0", i20, ph(g20, 2), m20);
        end
    endtask

    task automatic test_fault_blank();
        do_reset();
        set_req(0, 2'b10);
        set_req(1, 2'b01);
        set_req(2, 2'b11);
        @(negedge clk);
        set_req(2, 2'b10);
        repeat (3) @(negedge clk);
        vectors++;
        if (g20 !== 6'b100110 || i20 !== 3'b100) begin
            miscompares++;
            $display("FAIL f_active: got g=%b ill=%b expected 100110 100", g20, i20);
        end
        set_req(0, 2'b01);
        repeat (10) @(negedge clk);
        faultIn = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (g20 !== 6'b0 || m20 !== 1'b1) begin
            miscompares++;
            $display("FAIL f_blank: got g=%b m=%b expected 000000 1", g20, m20);
        end
        faultClr = 1'b1;
        @(negedge clk);
        faultClr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (g20 !== 6'b0 || m20 !== 1'b1 || i20 !== 3'b100) begin
                miscompares++;
                $display("FAIL f_clr_ignored cyc%0d: got g=%b m=%b ill=%b expected 000000 1 100",
                         i, g20, m20, i20);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_fault_clear();
        set_req(0, 2'b10);
        set_req(1, 2'b10);
        set_req(2, 2'b10);
        faultIn = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (g20 !== 6'b0 || m20 !== 1'b1) begin
            miscompares++;
            $display("FAIL fc_held: got g=%b m=%b expected 000000 1", g20, m20);
        end
        faultClr = 1'b1;
        @(negedge clk);
        faultClr = 1'b0;
        vectors++;
        if (m20 !== 1'b0 || i20 !== 3'b000 || g20 !== 6'b0) begin
            miscompares++;
            $display("FAIL fc_clear: got m=%b ill=%b g=%b expected 0 000 000000", m20, i20, g20);
        end
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            vectors++;
            if (g20 !== 6'b0) begin
                miscompares++;
                $display("FAIL fc_dead cyc%0d: got %b expected 000000", i, g20);
            end
        end
        @(negedge clk);
        vectors++;
        if (g20 !== 6'b101010) begin
            miscompares++;
            $display("FAIL fc_resume: got %b expected 101010", g20);
        end
    endtask

    // Reference model in absolute time: a handover opens a gap ending at a
    // fixed cycle; the request present at that cycle picks the next side.
    task automatic test_random();
        int          dv[3];
        int          side[3][3];      // 0 off, 1 high, 2 low
        bit          dead[3][3];
        longint      t_end[3][3];
        int          last_on[3][3];
        int          zeros[3][3];
        logic [2:0]  ill_exp;
        int          hold[3];
        logic [1:0]  cur[3];
        longint      cyc;
        dv = '{20, 1, 255};
        do_reset();
        ill_exp = '0;
        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < 3; p++) begin
                side[k][p] = 0; dead[k][p] = 1'b0; t_end[k][p] = 0;
                last_on[k][p] = 0; zeros[k][p] = 0;
            end
        end
        for (int p = 0; p < 3; p++) begin
            hold[p] = 0;
            cur[p]  = 2'b00;
        end
        cyc = 0;
        for (int n = 0; n < 10000; n++) begin
            for (int k = 0; k < 3; k++) begin
                logic [5:0] got;
                logic [5:0] exp;
                got = get_g(k);
                exp = '0;
                for (int p = 0; p < 3; p++) begin
                    logic [1:0] o;
                    int         os;
                    if (side[k][p] == 1) exp[5-2*p -: 2] = 2'b10;
                    if (side[k][p] == 2) exp[5-2*p -: 2] = 2'b01;
                    o  = ph(got, p);
                    os = (o == 2'b10) ? 1 : (o == 2'b01) ? 2 : (o == 2'b11) ? 3 : 0;
                    vectors++;
                    if (os == 3) begin
                        miscompares++;
                        $display("FAIL rnd_overlap D=%0d ph%0d cyc%0d: got 11 expected not 11",
                                 dv[k], p, cyc);
                    end
                    if (os == 0) begin
                        zeros[k][p]++;
                    end else begin
                        if (last_on[k][p] != 0 && os != last_on[k][p]) begin
                            vectors++;
                            if (zeros[k][p] < dv[k]) begin
                                miscompares++;
                                $display("FAIL rnd_gap D=%0d ph%0d cyc%0d: got gap %0d expected >= %0d",
                                         dv[k], p, cyc, zeros[k][p], dv[k]);
                            end
                        end
                        last_on[k][p] = os;
                        zeros[k][p]   = 0;
                    end
                end
                vectors++;
                if (got !== exp || get_i(k) !== ill_exp || get_m(k) !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rnd_out D=%0d cyc%0d: got g=%b ill=%b m=%b expected %b %b 0",
                             dv[k], cyc, got, get_i(k), get_m(k), exp, ill_exp);
                end
            end
            for (int p = 0; p < 3; p++) begin
                if (hold[p] == 0) begin
                    int r;
                    r = $urandom_range(0, 9);
                    cur[p] = (r < 4) ? 2'b10 : (r < 8) ? 2'b01 : (r == 8) ? 2'b00 : 2'b11;
                    hold[p] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6)
                                                          : $urandom_range(1, 400);
                end
                hold[p]--;
                set_req(p, cur[p]);
                if (cur[p] == 2'b11) ill_exp[p] = 1'b1;
            end
            for (int k = 0; k < 3; k++) begin
                for (int p = 0; p < 3; p++) begin
                    int rs;
                    rs = (cur[p] == 2'b10) ? 1 : (cur[p] == 2'b01) ? 2 : 0;
                    if (dead[k][p]) begin
                        if (cyc >= t_end[k][p]) begin
                            dead[k][p] = 1'b0;
                            side[k][p] = rs;
                        end
                    end else if (side[k][p] != 0) begin
                        if (rs != side[k][p]) begin
                            dead[k][p]  = 1'b1;
                            side[k][p]  = 0;
                            t_end[k][p] = cyc + dv[k];
                        end
                    end else begin
                        side[k][p] = rs;
                    end
                end
            end
            cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_a_handover();
        test_b_bounce();
        test_c_illegal();
        test_fault_blank();
        test_fault_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
